// File: rtl/dcache_pkg.sv
// Shared types and helpers for the N-way data cache.
//   width_e     : CPU access width encoding (unsigned forms are loads only)
//   state_e     : cache controller states
//   load_extract: pick the addressed byte/half out of a word and extend it
//   byte_en     : byte-lane enables for a store of the given width/offset
//   store_lanes : move right-justified store data into its byte lane(s)
package dcache_pkg;

  typedef enum logic [2:0] {
    WID_W  = 3'b000,
    WID_H  = 3'b001,
    WID_B  = 3'b010,
    WID_HU = 3'b101,
    WID_BU = 3'b110
  } width_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_FLUSH
  } state_e;

  // Half-word accesses use off[1] only, so a misaligned half aligns down.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input width_e      wid,
                                               input logic [1:0]  off);
    logic [15:0] half;
    logic [7:0]  byt;
    logic [31:0] res;
    half = off[1] ? word[31:16] : word[15:0];
    byt  = word[{off, 3'b000} +: 8];
    case (wid)
      WID_H:   res = {{16{half[15]}}, half};
      WID_HU:  res = {16'h0, half};
      WID_B:   res = {{24{byt[7]}}, byt};
      WID_BU:  res = {24'h0, byt};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] byte_en(input width_e wid, input logic [1:0] off);
    logic [3:0] be;
    case (wid)
      WID_H, WID_HU: be = off[1] ? 4'b1100 : 4'b0011;
      WID_B, WID_BU: be = 4'b0001 << off;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

  // Lanes outside the enabled bytes are driven to zero.
  function automatic logic [31:0] store_lanes(input logic [31:0] data,
                                              input width_e      wid,
                                              input logic [1:0]  off);
    logic [31:0] res;
    case (wid)
      WID_H, WID_HU: res = {16'h0, data[15:0]} << {off[1], 4'b0000};
      WID_B, WID_BU: res = {24'h0, data[7:0]} << {off, 3'b000};
      default:       res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the set-associative cache: per-set valid bit, tag and data word.
//   clk, rst_n : clock, async active-low reset (clears valid, tag, data)
//   clr        : invalidate every set of this way on the next edge
//   idx, tag   : set index and tag of the current access
//   fill_en    : write tag + full word, mark valid
//   st_en      : lane-masked data update of an already valid line
//   wdata, be  : write data (already lane aligned) and byte enables
//   hit        : line at idx is valid and tag matches
//   vld        : line at idx is valid (victim selection)
//   rd         : data word stored at idx
module dcache_way
  import dcache_pkg::*;
#(
  parameter int SETBITS = 2,
  parameter int TAG_W   = 28
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [SETBITS-1:0] idx,
  input  logic [TAG_W-1:0]   tag,
  input  logic               fill_en,
  input  logic               st_en,
  input  logic [31:0]        wdata,
  input  logic [3:0]         be,
  output logic               hit,
  output logic               vld,
  output logic [31:0]        rd
);
  localparam int SETS = 1 << SETBITS;

  logic [SETS-1:0]             valid_q, valid_d;
  logic [SETS-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [SETS-1:0][31:0]       data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      tag_d[idx]   = tag;
    end
    if (fill_en || st_en) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) data_d[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    if (clr) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign vld = valid_q[idx];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);
  assign rd  = data_q[idx];

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative, write-through, no-write-allocate data cache.
//   clk, rst_n           : clock, async active-low reset
//   req_valid/we/width   : CPU request (held while stall=1), addr, wdata
//   flush                : invalidate all lines (sampled only when idle)
//   rdata, stall         : load result (valid when !stall) and CPU hold
//   mem_req/we/addr/wdata/be, mem_ready, mem_rdata : memory handshake
//   hit_cnt, miss_cnt    : saturating load hit / miss counters
module dcache_nway
  import dcache_pkg::*;
#(
  parameter int SETBITS = 2,
  parameter int WAYS    = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_width,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             flush,
  output logic [31:0]      rdata,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int SETS  = 1 << SETBITS;
  localparam int TAG_W = 30 - SETBITS;
  localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [SETBITS-1:0] idx;
  logic [TAG_W-1:0]   tag;
  width_e             wid;
  logic [3:0]         st_be;
  logic [31:0]        st_data;

  assign idx     = addr[SETBITS+1:2];
  assign tag     = addr[31:SETBITS+2];
  assign wid     = width_e'(req_width);
  assign st_be   = byte_en(wid, addr[1:0]);
  assign st_data = store_lanes(wdata, wid, addr[1:0]);

  state_e                     state_q, state_d;
  logic                       done_q, done_d;   // store just finished; release it once
  logic [SETS-1:0][RR_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0]           hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [WAYS-1:0]            hit_vec, vld_vec, fill_we, st_we;
  logic [WAYS-1:0][31:0]      rd_vec;
  logic                       way_clr, hit, any_inv;
  logic [31:0]                hit_word, way_wdata;
  logic [3:0]                 way_be;
  logic [RR_W-1:0]            victim;
  logic                       stall_c, mem_req_c, mem_we_c;
  logic [3:0]                 mem_be_c;
  logic [31:0]                rdata_c;

  assign way_wdata = (state_q == ST_FILL) ? mem_rdata : st_data;
  assign way_be    = (state_q == ST_FILL) ? 4'b1111   : st_be;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(.SETBITS(SETBITS), .TAG_W(TAG_W)) u_way (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (way_clr),
      .idx     (idx),
      .tag     (tag),
      .fill_en (fill_we[w]),
      .st_en   (st_we[w]),
      .wdata   (way_wdata),
      .be      (way_be),
      .hit     (hit_vec[w]),
      .vld     (vld_vec[w]),
      .rd      (rd_vec[w])
    );
  end

  assign hit = |hit_vec;

  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_word = hit_word | rd_vec[w];
  end

  // Lowest-index invalid way wins; otherwise the set's round-robin way.
  always_comb begin
    victim  = rr_q[idx];
    any_inv = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!any_inv && !vld_vec[w]) begin
        victim  = RR_W'(w);
        any_inv = 1'b1;
      end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    rr_d       = rr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    stall_c    = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    mem_be_c   = 4'b0000;
    rdata_c    = '0;
    fill_we    = '0;
    st_we      = '0;
    way_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_FLUSH;
          stall_c = req_valid && !(req_we && done_q);
        end else if (req_valid && req_we) begin
          if (!done_q) begin
            stall_c = 1'b1;
            state_d = ST_WRITE;
          end
        end else if (req_valid) begin
          if (hit) begin
            rdata_c   = load_extract(hit_word, wid, addr[1:0]);
            hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
          end else begin
            stall_c    = 1'b1;
            miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
            state_d    = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        stall_c   = 1'b1;
        mem_req_c = 1'b1;
        mem_be_c  = 4'b1111;
        if (mem_ready) begin
          fill_we[victim] = 1'b1;
          if (!any_inv)
            rr_d[idx] = (rr_q[idx] == RR_W'(WAYS-1)) ? '0 : rr_q[idx] + 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        stall_c   = 1'b1;
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        mem_be_c  = st_be;
        if (mem_ready) begin
          st_we   = hit_vec;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        stall_c = 1'b1;
        way_clr = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      rr_q       <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      rr_q       <= rr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert ($onehot0(hit_vec));
  end

  // Gate with rst_n so the handshake drops the instant reset asserts.
  assign stall     = rst_n & stall_c;
  assign mem_req   = rst_n & mem_req_c;
  assign mem_we    = rst_n & mem_we_c;
  assign mem_be    = rst_n ? mem_be_c : 4'b0000;
  assign rdata     = rst_n ? rdata_c  : '0;
  assign mem_addr  = {addr[31:2], 2'b00};
  assign mem_wdata = st_data;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_nway.sv
module tb_dcache_nway;
  localparam int SETBITS = 2;
  localparam int WAYS    = 2;
  localparam int CNT_W   = 5;
  localparam int SETS    = 1 << SETBITS;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic clk = 1'b0, rst_n;
  logic req_valid, req_we, flush, mem_req, mem_we, mem_ready, stall;
  logic [2:0] req_width;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  dcache_nway #(.SETBITS(SETBITS), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_width(req_width), .addr(addr), .wdata(wdata), .flush(flush),
    .rdata(rdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0, lat = 2;
  logic [31:0] mem_m [logic [31:0]];   // memory as seen through the DUT's bus
  logic [31:0] ref_m [logic [31:0]];   // memory as the reference model expects
  logic [3:0]  cap_be;
  logic [31:0] cap_mwd;

  // reference cache contents
  bit          mv   [SETS][WAYS];
  logic [31:0] mtag [SETS][WAYS];
  int          mrr  [SETS];
  logic [CNT_W-1:0] hit_m, miss_m;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction
  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : dflt(a);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] wd, input logic [31:0] a);
    logic [31:0] w, v;
    int off;
    w = ref_rd({a[31:2], 2'b00});
    off = int'(a[1:0]);
    case (wd)
      3'b001, 3'b101: begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (wd == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      3'b010, 3'b110: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (wd == 3'b010 && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic exp_store(input logic [2:0] wd, input logic [31:0] a, input logic [31:0] d,
                           output logic [3:0] be, output logic [31:0] md);
    int off;
    logic [31:0] w, wa;
    off = int'(a[1:0]);
    wa = {a[31:2], 2'b00};
    case (wd)
      3'b010:  begin be = 4'b0001 << off;           md = (d & 32'hFF) << (8 * off); end
      3'b001:  begin be = 4'b0011 << (2 * (off/2)); md = (d & 32'hFFFF) << (16 * (off/2)); end
      default: begin be = 4'b1111;                  md = d; end
    endcase
    w = ref_rd(wa);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = md[8*b +: 8];
    ref_m[wa] = w;
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    int s = int'((a >> 2) % SETS);
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mtag[s][w] == (a >> (SETBITS + 2))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_fill(input logic [31:0] a);
    int s = int'((a >> 2) % SETS);
    int v = -1;
    for (int w = 0; w < WAYS; w++) if (v < 0 && !mv[s][w]) v = w;
    if (v < 0) begin
      v = mrr[s];
      mrr[s] = (mrr[s] + 1) % WAYS;
    end
    mv[s][v] = 1'b1;
    mtag[s][v] = a >> (SETBITS + 2);
  endfunction

  function automatic void m_clear(input bit full);
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
      if (full) mrr[s] = 0;
    end
    if (full) begin hit_m = '0; miss_m = '0; end
  endfunction

  // memory responder: ready after lat idle cycles of mem_req, for one cycle
  initial begin
    int wcnt;
    logic [31:0] w;
    wcnt = 0; mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0; wcnt = 0;
      end else if (mem_req) begin
        if (wcnt >= lat) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            w = mm_rd(mem_addr);
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_m[mem_addr] = w;
          end else mem_rdata = mm_rd(mem_addr);
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // One CPU access; returns number of stalled cycles and the rdata seen when stall fell.
  task automatic access(input logic we, input logic [2:0] wd, input logic [31:0] a,
                        input logic [31:0] d, output int ncyc, output logic [31:0] rd);
    req_valid = 1'b1; req_we = we; req_width = wd; addr = a; wdata = d;
    ncyc = 0; cap_be = '0; cap_mwd = '0;
    forever begin
      @(negedge clk);
      if (mem_req && mem_we) begin cap_be = mem_be; cap_mwd = mem_wdata; end
      if (!stall) break;
      ncyc++;
      if (ncyc > 100) begin chk("timeout", 32'(ncyc), 0); break; end
    end
    rd = rdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(posedge clk); #1;
    m_clear(1'b0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  wd;
    logic [31:0] a, d, exp_rd;
    logic        exp_miss;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwd;
  } vec_t;

  vec_t tbl[14];
  int nc, nload, nmiss;
  logic [31:0] rd, er, md;
  logic [3:0]  be;
  logic [2:0]  wds[5];
  bit h;

  initial begin
    tbl[0]  = '{0, 3'b000, 32'h100, 0, 32'hDEADBEEF, 1, 0, 0};
    tbl[1]  = '{0, 3'b010, 32'h103, 0, 32'hFFFFFFDE, 0, 0, 0};
    tbl[2]  = '{0, 3'b110, 32'h103, 0, 32'h000000DE, 0, 0, 0};
    tbl[3]  = '{0, 3'b001, 32'h102, 0, 32'hFFFFDEAD, 0, 0, 0};
    tbl[4]  = '{0, 3'b101, 32'h102, 0, 32'h0000DEAD, 0, 0, 0};
    tbl[5]  = '{0, 3'b010, 32'h100, 0, 32'hFFFFFFEF, 0, 0, 0};
    tbl[6]  = '{0, 3'b000, 32'h110, 0, dflt(32'h110), 1, 0, 0};
    tbl[7]  = '{0, 3'b000, 32'h120, 0, dflt(32'h120), 1, 0, 0};
    tbl[8]  = '{0, 3'b000, 32'h110, 0, dflt(32'h110), 0, 0, 0};
    tbl[9]  = '{0, 3'b000, 32'h100, 0, 32'hDEADBEEF, 1, 0, 0};
    tbl[10] = '{1, 3'b010, 32'h101, 32'h55, 0, 0, 4'b0010, 32'h00005500};
    tbl[11] = '{0, 3'b000, 32'h100, 0, 32'hDEAD55EF, 0, 0, 0};
    tbl[12] = '{1, 3'b000, 32'h200, 32'h12345678, 0, 0, 4'b1111, 32'h12345678};
    tbl[13] = '{0, 3'b000, 32'h200, 0, 32'h12345678, 1, 0, 0};
    wds = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};
    mem_m[32'h100] = 32'hDEADBEEF;
    ref_m[32'h100] = 32'hDEADBEEF;
    m_clear(1'b1);

    // reset with a load already presented: outputs must stay quiet
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_width = 3'b000;
    addr = 32'h100; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    @(posedge clk); #1 rst_n = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;

    // directed vectors, fixed latency
    lat = 2; nload = 0; nmiss = 0;
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].we) begin
        exp_store(tbl[i].wd, tbl[i].a, tbl[i].d, be, md);
        access(1'b1, tbl[i].wd, tbl[i].a, tbl[i].d, nc, rd);
        chk($sformatf("v%0d_be", i), 32'(cap_be), 32'(tbl[i].exp_be));
        chk($sformatf("v%0d_mwdata", i), cap_mwd, tbl[i].exp_mwd);
        chk($sformatf("v%0d_st_cycles", i), 32'(nc), 4);
      end else begin
        if (!m_hit(tbl[i].a)) m_fill(tbl[i].a);
        access(1'b0, tbl[i].wd, tbl[i].a, 0, nc, rd);
        chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
        chk($sformatf("v%0d_stall_cycles", i), 32'(nc), tbl[i].exp_miss ? 4 : 0);
        nload++;
        if (tbl[i].exp_miss) nmiss++;
      end
    end
    chk("dir_hit_cnt", 32'(hit_cnt), 32'(nload));
    chk("dir_miss_cnt", 32'(miss_cnt), 32'(nmiss));

    // reset asserted in the middle of a fill
    lat = 10;
    req_valid = 1'b1; req_we = 1'b0; req_width = 3'b000; addr = 32'h300;
    repeat (3) @(negedge clk);
    chk("fill_stall", 32'(stall), 1);
    chk("fill_mem_req", 32'(mem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_mem_req", 32'(mem_req), 0);
    chk("midrst_mem_be", 32'(mem_be), 0);
    chk("midrst_miss_cnt", 32'(miss_cnt), 0);
    @(posedge clk); #1 req_valid = 1'b0; rst_n = 1'b1;
    m_clear(1'b1);
    lat = 2;
    @(posedge clk); #1;
    access(1'b0, 3'b000, 32'h100, 0, nc, rd);
    m_fill(32'h100); miss_m++; hit_m++;
    chk("postrst_miss", 32'(nc), 4);
    chk("postrst_rdata", rd, 32'hDEAD55EF);
    access(1'b0, 3'b000, 32'h100, 0, nc, rd);
    hit_m++;
    chk("postrst_hit", 32'(nc), 0);

    // flush: one stalled cycle, then everything misses
    flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", 32'(stall), 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", 32'(stall), 1);
    @(posedge clk); #1;
    m_clear(1'b0);
    access(1'b0, 3'b000, 32'h100, 0, nc, rd);
    m_fill(32'h100); miss_m++; hit_m++;
    chk("postflush_miss", 32'(nc), 4);

    // flush pulsed during a fill is ignored
    fork
      access(1'b0, 3'b000, 32'h144, 0, nc, rd);
      begin
        @(posedge clk); @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
      end
    join
    m_fill(32'h144); miss_m++; hit_m++;
    chk("fillflush_rdata", rd, dflt(32'h144));
    access(1'b0, 3'b000, 32'h100, 0, nc, rd);
    hit_m++;
    chk("fillflush_keep", 32'(nc), 0);
    chk("cnt_hit", 32'(hit_cnt), 32'(hit_m));
    chk("cnt_miss", 32'(miss_cnt), 32'(miss_m));

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [2:0] wd;
      logic we;
      lat = $urandom_range(0, 3);
      if ($urandom_range(0, 49) == 0) do_flush();
      a = 32'h1000 | ($urandom_range(0, 5) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      we = ($urandom_range(0, 2) == 0);
      if (we) begin
        wd = wds[$urandom_range(0, 2)];
        wdata = $urandom;
        exp_store(wd, a, wdata, be, md);
        access(1'b1, wd, a, wdata, nc, rd);
        chk("rnd_be", 32'(cap_be), 32'(be));
        chk("rnd_mwdata", cap_mwd, md);
        chk("rnd_st_stalled", 32'(nc >= 2), 1);
      end else begin
        wd = wds[$urandom_range(0, 4)];
        h = m_hit(a);
        er = exp_load(wd, a);
        access(1'b0, wd, a, 0, nc, rd);
        chk("rnd_rdata", rd, er);
        chk("rnd_hitmiss", 32'(nc == 0), 32'(h));
        if (!h) begin
          m_fill(a);
          if (miss_m != CMAX) miss_m++;
        end
        if (hit_m != CMAX) hit_m++;
        chk("rnd_hit_cnt", 32'(hit_cnt), 32'(hit_m));
        chk("rnd_miss_cnt", 32'(miss_cnt), 32'(miss_m));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
